// File: rtl/imem_loader.sv
// imem_loader: instruction memory with a streaming valid/ready boot loader.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc, instr           fetch byte address, fetched word (NOP while loading)
//   misaligned          pc[1:0] != 0
//   ld_start/base/count load request (sampled in IDLE only)
//   ld_valid/data/ready word stream into memory
//   ld_busy             load in progress, core must hold its PC
//   ld_done, ld_err     one-cycle completion / misaligned-base pulses
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter bit REG_READ = 1'b0,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              misaligned,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W-2:0] ld_count,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [ADDR_W-2:0] ONE = 1;
    logic [DATA_W-1:0] mem [0:(1<<(ADDR_W-2))-1];
    state_t state_q, state_d;
    logic [ADDR_W-3:0] ptr_q, ptr_d;
    logic [ADDR_W-2:0] rem_q, rem_d;
    logic we;
    logic [DATA_W-1:0] rd;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            rem_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            rem_q <= rem_d;
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        rem_d = rem_q;
        ld_ready = 1'b0;
        ld_busy = 1'b0;
        ld_done = 1'b0;
        ld_err = 1'b0;
        we = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    if (|ld_base[1:0]) begin
                        ld_err = 1'b1;
                    end else if (ld_count == '0) begin
                        state_d = DONE;
                    end else begin
                        ptr_d = ld_base[ADDR_W-1:2];
                        rem_d = ld_count;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                ld_busy = 1'b1;
                if (ld_valid) begin
                    we = 1'b1;
                    // pointer is exactly one word-index wide, so it wraps naturally
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == ONE) state_d = DONE;
                end
            end
            DONE: begin
                ld_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // memory contents survive reset, so the write port has no reset
    always_ff @(posedge clk) begin
        if (we) mem[ptr_q] <= ld_data;
    end
    generate
        if (REG_READ) begin : g_reg
            logic [DATA_W-1:0] rd_q;
            // nonblocking read of mem gives read-before-write on a same-cycle hit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) rd_q <= '0;
                else rd_q <= mem[pc[ADDR_W-1:2]];
            end
            assign rd = rd_q;
        end else begin : g_comb
            assign rd = mem[pc[ADDR_W-1:2]];
        end
    endgenerate
    assign misaligned = |pc[1:0];
    assign instr = ld_busy ? NOP_WORD : rd;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (both read modes).
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] pc = '0, pc1 = '0;
    logic [31:0] instr, instr1;
    logic mis, mis1;
    logic ld_start = 1'b0, ld_valid = 1'b0;
    logic [9:0] ld_base = '0;
    logic [8:0] ld_count = '0;
    logic [31:0] ld_data = '0;
    logic ld_ready, ld_busy, ld_done, ld_err;
    logic ld_ready1, ld_busy1, ld_done1, ld_err1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    imem_loader #(.REG_READ(1'b0)) d0 (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .misaligned(mis),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err)
    );

    imem_loader #(.REG_READ(1'b1)) d1 (
        .clk(clk), .rst(rst), .pc(pc1), .instr(instr1), .misaligned(mis1),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready1),
        .ld_busy(ld_busy1), .ld_done(ld_done1), .ld_err(ld_err1)
    );

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] instr;
        logic        mis;
    } vec_t;

    logic [31:0] orig [0:5] = '{32'h010000df, 32'h0800006f, 32'h40000513,
                                32'h40e00593, 32'h000006b3, 32'h04b50863};
    logic [31:0] wd [0:7];
    vec_t vt [0:7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one load from wd[]; counts cycles from the start-sampling edge to ld_done.
    task automatic do_load(input logic [9:0] base, input logic [8:0] cnt,
                           input bit stall, input int exp_cyc);
        int k = 0, cyc = 1, done_at = -1;
        bit nop_ok = 1'b1;
        ld_base = base;
        ld_count = cnt;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        while (cyc <= 40 && done_at < 0) begin
            ld_valid = stall ? cyc[0] : 1'b1;
            ld_data = wd[k];
            pc = 10'($urandom);
            #1;
            if (ld_busy && (instr !== 32'h00000013 || instr1 !== 32'h00000013)) nop_ok = 1'b0;
            if (ld_done) done_at = cyc;
            if (ld_valid && ld_ready) k++;
            step();
            cyc++;
        end
        ld_valid = 1'b0;
        chk("done_cycle", done_at, exp_cyc);
        chk("nop_during_load", {31'b0, nop_ok}, 32'd1);
    endtask

    task automatic read_word(input string nm, input logic [9:0] a, input logic [31:0] exp);
        pc = a;
        #1;
        chk(nm, instr, exp);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) vt[i] = '{10'(i * 4), orig[i], 1'b0};
        vt[6] = '{10'h006, 32'h0800006f, 1'b1};
        vt[7] = '{10'h013, 32'h000006b3, 1'b1};

        // reset held for two cycles
        step();
        step();
        chk("rst_busy", {31'b0, ld_busy}, 0);
        chk("rst_done", {31'b0, ld_done}, 0);
        chk("rst_err", {31'b0, ld_err}, 0);
        chk("rst_ready", {31'b0, ld_ready}, 0);
        chk("rst_instr_reg", instr1, 0);
        rst = 1'b0;
        step();

        // back-to-back load, done 7 cycles after start
        for (int i = 0; i < 6; i++) wd[i] = orig[i];
        do_load(10'h000, 9'd6, 1'b0, 7);
        for (int i = 0; i < 8; i++) begin
            pc = vt[i].pc;
            #1;
            chk("vec_instr", instr, vt[i].instr);
            chk("vec_mis", {31'b0, mis}, {31'b0, vt[i].mis});
        end

        // registered read: one-edge latency, misaligned still fetches pc>>2
        pc1 = 10'h000;
        step();
        pc1 = 10'h008;
        #1;
        chk("reg_old", instr1, orig[0]);
        step();
        chk("reg_new", instr1, orig[2]);
        pc1 = 10'h006;
        #1;
        chk("reg_mis", {31'b0, mis1}, 1);
        step();
        chk("reg_mis_word", instr1, orig[1]);

        // stalled load with inverted words, done 12 cycles after start
        for (int i = 0; i < 6; i++) wd[i] = ~orig[i];
        do_load(10'h000, 9'd6, 1'b1, 12);
        for (int i = 0; i < 6; i++) read_word("stall_rd", 10'(i * 4), ~orig[i]);

        // misaligned base: one-cycle ld_err, nothing else
        ld_base = 10'h002;
        ld_count = 9'd3;
        ld_start = 1'b1;
        #1;
        chk("err_pulse", {31'b0, ld_err}, 1);
        chk("err_done", {31'b0, ld_done}, 0);
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data = 32'hdeadbeef;
        #1;
        chk("err_clear", {31'b0, ld_err}, 0);
        chk("err_busy", {31'b0, ld_busy}, 0);
        step();
        ld_valid = 1'b0;
        read_word("err_mem", 10'h000, ~orig[0]);

        // zero count: done one cycle after start, no write
        wd[0] = 32'h12345678;
        do_load(10'h000, 9'd0, 1'b0, 1);
        read_word("zero_mem", 10'h000, ~orig[0]);

        // reset after 3 of 6 words: no done, partial contents retained
        ld_base = 10'h000;
        ld_count = 9'd6;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data = orig[i];
            step();
        end
        ld_data = orig[3];
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, ld_busy}, 0);
        chk("abort_ready", {31'b0, ld_ready}, 0);
        step();
        rst = 1'b0;
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("abort_no_done", {31'b0, ld_done}, 0);
            step();
        end
        for (int i = 0; i < 6; i++) read_word("abort_rd", 10'(i * 4), i < 3 ? orig[i] : ~orig[i]);

        // wrap from the last word to word 0
        wd[0] = 32'haaaa0001;
        wd[1] = 32'haaaa0002;
        do_load(10'h3fc, 9'd2, 1'b0, 3);
        read_word("wrap_last", 10'h3fc, 32'haaaa0001);
        read_word("wrap_first", 10'h000, 32'haaaa0002);
        read_word("wrap_keep", 10'h004, orig[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
